// File: rtl/adc_rx_multi.sv
// Multi-channel serial ADC receiver: shifts CHANNELS lines in parallel per CS frame,
// rejects frames with nonzero leading bits, and averages 2^AVG_LOG2 good frames per output.
module adc_rx_multi #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned OUT_BITS   = 8,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                           SCLK,
  input  logic                           reset,
  input  logic                           CS,
  input  logic [CHANNELS-1:0]            SDATA,
  output logic                           rx_done_tick,
  output logic [CHANNELS*FRAME_BITS-1:0] b_reg,
  output logic [CHANNELS*OUT_BITS-1:0]   data_Out,
  output logic                           frame_err
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam int unsigned AccW = DATA_BITS + AVG_LOG2;
  localparam int unsigned AvgW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_BITS - 1);
  localparam logic [AvgW-1:0] AvgN    = AvgW'(1 << AVG_LOG2);
  // Ones over the leading-zero field; all zeros when DATA_BITS == FRAME_BITS.
  localparam logic [FRAME_BITS-1:0] LeadMask =
      ~({FRAME_BITS{1'b1}} >> (FRAME_BITS - DATA_BITS));

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [FRAME_BITS-2:0]           sh_q [CHANNELS];
  logic [FRAME_BITS-2:0]           sh_d [CHANNELS];
  logic [AccW-1:0]                 acc_q [CHANNELS];
  logic [AccW-1:0]                 acc_d [CHANNELS];
  logic [AvgW-1:0]                 avg_q, avg_d;
  logic [CHANNELS*FRAME_BITS-1:0]  b_reg_q, b_reg_d;
  logic [CHANNELS*OUT_BITS-1:0]    dout_q, dout_d;
  logic                            tick_q, tick_d;
  logic                            err_q, err_d;

  // Full frame = stored bits plus the bit arriving on this edge.
  logic [FRAME_BITS-1:0]           frame   [CHANNELS];
  logic [AccW-1:0]                 acc_sum [CHANNELS];
  logic                            lead_bad;
  logic [AvgW-1:0]                 avg_inc;

  always_comb begin
    lead_bad = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame[k]   = {sh_q[k], SDATA[k]};
      acc_sum[k] = acc_q[k] + AccW'(frame[k][DATA_BITS-1:0]);
      lead_bad   = lead_bad | (|(frame[k] & LeadMask));
    end
    avg_inc = avg_q + AvgW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    avg_d   = avg_q;
    b_reg_d = b_reg_q;
    dout_d  = dout_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!CS) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (CS) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          for (int k = 0; k < CHANNELS; k++) sh_d[k] = frame[k][FRAME_BITS-2:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            if (lead_bad) begin
              err_d = 1'b1;
            end else begin
              for (int k = 0; k < CHANNELS; k++) begin
                b_reg_d[k*FRAME_BITS +: FRAME_BITS] = frame[k];
                acc_d[k] = acc_sum[k];
              end
              if (avg_inc == AvgN) begin
                for (int k = 0; k < CHANNELS; k++) begin
                  dout_d[k*OUT_BITS +: OUT_BITS] = acc_sum[k][AccW-1 -: OUT_BITS];
                  acc_d[k] = '0;
                end
                avg_d  = '0;
                tick_d = 1'b1;
              end else begin
                avg_d = avg_inc;
              end
            end
          end
        end
      end
      StDone: begin
        if (CS) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '{default: '0};
      acc_q   <= '{default: '0};
      avg_q   <= '0;
      b_reg_q <= '0;
      dout_q  <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      b_reg_q <= b_reg_d;
      dout_q  <= dout_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign rx_done_tick = tick_q;
  assign frame_err    = err_q;
  assign b_reg        = b_reg_q;
  assign data_Out     = dout_q;

endmodule
